// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer: pops FWFT Tx FIFO bytes and frames them start/LSB-first data/stop.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 fifo_empty,
  input  logic                 tx_pause,
  output logic                 fifo_deq,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 byte_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]           state_reg;
  logic [BAUD_W-1:0]    baud_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end;

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty && !tx_pause)
            state_reg <= LOAD;
        end
        LOAD: begin
          // The byte is owned by the shift register from here on; FIFO changes no longer matter.
          shift_reg <= tx_data;
          baud_reg  <= '0;
          bit_reg   <= '0;
          state_reg <= START;
        end
        START: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_reg   <= bit_reg + 1'b1;
            if (bit_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      parity_reg <= 1'b0;
    else if (state_reg == LOAD)
      parity_reg <= ^tx_data;
  end
`endif

  // Line level decodes from registered state only, so reset forces it high at once.
  always_comb begin
    tx_serial = 1'b1;
    case (state_reg)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_serial = parity_reg;
`endif
      default: tx_serial = 1'b1;
    endcase
  end

  assign fifo_deq  = (state_reg == LOAD);
  assign tx_busy   = (state_reg != IDLE);
  assign byte_done = (state_reg == STOP) && bit_end;

endmodule
